// File: rtl/rrat_pkg.sv
// Shared types and constants for the retirement RAT and its helpers.
package rrat_pkg;

   localparam int NUM_AREG  = 32;
   localparam int NUM_PREG  = 64;
   localparam int TAG_W     = $clog2(NUM_PREG);
   localparam int AREG_W    = $clog2(NUM_AREG);
   localparam int GROUP     = 4;
   localparam int NUM_BEATS = NUM_AREG / GROUP;
   localparam int IDX_W     = $clog2(NUM_BEATS);
   localparam int BEAT_W    = GROUP * TAG_W;

   typedef enum logic [1:0] {
      IDLE,
      RESTORE,
      DONE
   } rrat_state_e;

   // Lowest arch register of the group lands in the lowest tag slot.
   function automatic logic [BEAT_W-1:0] pack_beat(input logic [TAG_W-1:0] t0,
                                                   input logic [TAG_W-1:0] t1,
                                                   input logic [TAG_W-1:0] t2,
                                                   input logic [TAG_W-1:0] t3);
      return {t3, t2, t1, t0};
   endfunction

endpackage

// File: rtl/rrat_commit_if.sv
// Commit, free-list and restore signals between the ROB side and the retirement RAT.
interface rrat_commit_if;
   import rrat_pkg::*;

   logic                commit_valid;
   logic [AREG_W-1:0]   commit_areg;
   logic [TAG_W-1:0]    commit_preg;
   logic                commit_stall;
   logic                flush;
   logic                free_valid;
   logic [TAG_W-1:0]    free_tag;
   logic                free_ready;
   logic                restore_valid;
   logic [IDX_W-1:0]    restore_idx;
   logic [BEAT_W-1:0]   restore_tags;
   logic                restore_done;
   logic                overflow_err;

   // ROB / free list / rename stage side.
   modport master (
      output commit_valid, commit_areg, commit_preg, flush, free_ready,
      input  commit_stall, free_valid, free_tag, restore_valid, restore_idx,
             restore_tags, restore_done, overflow_err
   );

   // Retirement RAT side.
   modport slave (
      input  commit_valid, commit_areg, commit_preg, flush, free_ready,
      output commit_stall, free_valid, free_tag, restore_valid, restore_idx,
             restore_tags, restore_done, overflow_err
   );

endinterface

// File: rtl/freed_tag_fifo.sv
// Small synchronous FIFO; a push and a pop in the same cycle are both honoured, even when full.
module freed_tag_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 6
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == FULL_CNT);
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign pop_data = mem[rd_ptr];

   // Storage write.
   // NOTE: the array is deliberately not reset; an entry is only read after count marks it valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
   // NOTE: state is written with <= so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rrat_commit.sv
// Retirement RAT: committed arch->phys map, freed-tag queue and flush-time map restore.
module rrat_commit
   import rrat_pkg::*;
#(
   parameter int FREE_Q_DEPTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   rrat_commit_if.slave  bus
);

   localparam int CNT_W = $clog2(FREE_Q_DEPTH) + 1;
   localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(FREE_Q_DEPTH - 1);

   logic [TAG_W-1:0] map [NUM_AREG];
   rrat_state_e      state;
   rrat_state_e      state_next;
   logic [IDX_W-1:0] beat;
   logic [IDX_W-1:0] beat_next;
   logic             overflow_q;

   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic             accept;
   logic [TAG_W-1:0] push_tag;

   assign pop    = bus.free_valid & bus.free_ready;
   // A full queue still takes a commit when a pop frees a slot in the same cycle.
   assign accept = bus.commit_valid & (state == IDLE) & (~fifo_full | pop);
   // A write to $0 is never mapped, so its own allocation goes straight back to the free list.
   assign push_tag = (bus.commit_areg != '0) ? map[bus.commit_areg] : bus.commit_preg;

   freed_tag_fifo #(
      .DEPTH (FREE_Q_DEPTH),
      .WIDTH (TAG_W)
   ) u_free_q (
      .clk       (clk),
      .reset     (reset),
      .push      (accept),
      .push_data (push_tag),
      .pop       (pop),
      .pop_data  (bus.free_tag),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Committed map update and sticky dropped-commit flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_AREG; i++) map[i] <= TAG_W'(i);
         overflow_q <= 1'b0;
      end else begin
         if (accept && bus.commit_areg != '0) map[bus.commit_areg] <= bus.commit_preg;
         if (bus.commit_valid && !accept)     overflow_q <= 1'b1;
      end
   end

   // Restore FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         beat  <= '0;
      end else begin
         state <= state_next;
         beat  <= beat_next;
      end
   end

   // Restore FSM next state; any flush (re)starts the walk from beat 0.
   // NOTE: defaults come first so every path assigns every output and no latch is inferred.
   always_comb begin
      state_next = state;
      beat_next  = beat;
      case (state)
         IDLE: begin
            if (bus.flush) begin
               state_next = RESTORE;
               beat_next  = '0;
            end
         end
         RESTORE: begin
            if (bus.flush)                              beat_next  = '0;
            else if (beat == IDX_W'(NUM_BEATS - 1))     state_next = DONE;
            else                                        beat_next  = beat + 1'b1;
         end
         DONE: begin
            if (bus.flush) begin
               state_next = RESTORE;
               beat_next  = '0;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.free_valid    = ~fifo_empty;
   assign bus.overflow_err  = overflow_q;
   assign bus.commit_stall  = (fifo_count >= STALL_CNT) | (state != IDLE) | bus.flush;
   assign bus.restore_valid = (state == RESTORE);
   assign bus.restore_done  = (state == DONE);
   assign bus.restore_idx   = bus.restore_valid ? beat : '0;
   assign bus.restore_tags  = bus.restore_valid ?
                              pack_beat(map[{beat, 2'd0}], map[{beat, 2'd1}],
                                        map[{beat, 2'd2}], map[{beat, 2'd3}]) : '0;

endmodule

// File: tb/tb_rrat_commit.sv
// Directed bench for rrat_commit: commits, freed-tag queue, overflow and flush restore.
module tb_rrat_commit;
   import rrat_pkg::*;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   rrat_commit_if bus ();

   rrat_commit #(.FREE_Q_DEPTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [BEAT_W-1:0] beats [NUM_BEATS];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      bus.commit_valid = 1'b0;
      bus.commit_areg  = '0;
      bus.commit_preg  = '0;
      bus.flush        = 1'b0;
      bus.free_ready   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      quiet_inputs();
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic commit(input int areg, input int preg);
      bus.commit_valid = 1'b1;
      bus.commit_areg  = AREG_W'(areg);
      bus.commit_preg  = TAG_W'(preg);
      tick();
      bus.commit_valid = 1'b0;
      #1;
   endtask

   // Flush at cycle t (optionally with a commit), collect beats t+1..t+8, done at t+9, stall low at t+10.
   // exp_free >= 0 means a tag is expected at the queue head during beat 0 and drained by beat 2.
   task automatic run_restore(input string tag, input bit with_commit, input int areg,
                              input int preg, input int exp_free);
      bus.flush = 1'b1;
      if (with_commit) begin
         bus.commit_valid = 1'b1;
         bus.commit_areg  = AREG_W'(areg);
         bus.commit_preg  = TAG_W'(preg);
      end
      #1;
      check({tag, " stall_at_flush"}, 32'(bus.commit_stall), 32'd1);
      tick();
      bus.flush        = 1'b0;
      bus.commit_valid = 1'b0;
      #1;
      for (int b = 0; b < NUM_BEATS; b++) begin
         check({tag, " beat_valid"}, 32'(bus.restore_valid), 32'd1);
         check({tag, " beat_idx"},   32'(bus.restore_idx),   32'(b));
         check({tag, " beat_stall"}, 32'(bus.commit_stall),  32'd1);
         if (exp_free >= 0 && b == 0) begin
            check({tag, " free_valid_in_restore"}, 32'(bus.free_valid), 32'd1);
            check({tag, " free_tag_in_restore"},   32'(bus.free_tag),   32'(exp_free));
         end
         if (exp_free >= 0 && b == 2)
            check({tag, " drained_in_restore"}, 32'(bus.free_valid), 32'd0);
         beats[b] = bus.restore_tags;
         tick();
      end
      check({tag, " done_pulse"},    32'(bus.restore_done),  32'd1);
      check({tag, " valid_at_done"}, 32'(bus.restore_valid), 32'd0);
      check({tag, " stall_at_done"}, 32'(bus.commit_stall),  32'd1);
      tick();
      check({tag, " done_cleared"},  32'(bus.restore_done),  32'd0);
      check({tag, " stall_released"}, 32'(bus.commit_stall), 32'd0);
   endtask

   initial begin
      do_reset();

      // Reset state.
      check("rst commit_stall",  32'(bus.commit_stall),  32'd0);
      check("rst free_valid",    32'(bus.free_valid),    32'd0);
      check("rst restore_valid", 32'(bus.restore_valid), 32'd0);
      check("rst restore_idx",   32'(bus.restore_idx),   32'd0);
      check("rst restore_tags",  32'(bus.restore_tags),  32'd0);
      check("rst restore_done",  32'(bus.restore_done),  32'd0);
      check("rst overflow_err",  32'(bus.overflow_err),  32'd0);

      // 1: commit 5->40 frees tag 5, visible only from the next cycle.
      bus.commit_valid = 1'b1;
      bus.commit_areg  = 5'd5;
      bus.commit_preg  = 6'd40;
      #1;
      check("t1 free_valid_same_cycle", 32'(bus.free_valid), 32'd0);
      tick();
      bus.commit_valid = 1'b0;
      #1;
      check("t1 free_valid", 32'(bus.free_valid), 32'd1);
      check("t1 free_tag",   32'(bus.free_tag),   32'd5);
      bus.free_ready = 1'b1;
      tick();
      bus.free_ready = 1'b0;
      check("t1 popped", 32'(bus.free_valid), 32'd0);

      // 2: commit to $0 frees its own allocation.
      commit(0, 33);
      check("t2 free_tag", 32'(bus.free_tag), 32'd33);
      bus.free_ready = 1'b1;
      tick();
      bus.free_ready = 1'b0;

      run_restore("t1_restore", 1'b0, 0, 0, -1);
      check("t1 beat0", 32'(beats[0]), 32'(pack_beat(6'd0, 6'd1, 6'd2, 6'd3)));
      check("t1 beat1", 32'(beats[1]), 32'(pack_beat(6'd4, 6'd40, 6'd6, 6'd7)));
      check("t1 beat1 slot1", 32'(beats[1][11:6]), 32'd40);

      // 3: fill the queue with free_ready low; stall rises at 7 entries.
      do_reset();
      for (int k = 1; k <= 7; k++) begin
         commit(k, 31 + k);
         check("t3 stall_vs_count", 32'(bus.commit_stall), (k >= 7) ? 32'd1 : 32'd0);
      end
      commit(8, 39);
      check("t3 full_no_overflow", 32'(bus.overflow_err), 32'd0);
      check("t3 head",             32'(bus.free_tag),     32'd1);

      // 4: commit with a simultaneous pop while full is accepted.
      bus.free_ready = 1'b1;
      commit(9, 40);
      bus.free_ready = 1'b0;
      check("t4 no_overflow", 32'(bus.overflow_err), 32'd0);
      check("t4 head",        32'(bus.free_tag),     32'd2);
      check("t4 still_full",  32'(bus.commit_stall), 32'd1);

      // 3 (cont.): commit into a full queue without a pop is dropped.
      commit(10, 41);
      check("t3 overflow", 32'(bus.overflow_err), 32'd1);
      bus.free_ready = 1'b1;
      #1;
      for (int i = 2; i <= 9; i++) begin
         check("t3 drain_valid", 32'(bus.free_valid), 32'd1);
         check("t3 drain_order", 32'(bus.free_tag),   32'(i));
         tick();
      end
      check("t3 drained",      32'(bus.free_valid),   32'd0);
      check("t3 stall_low",    32'(bus.commit_stall), 32'd0);

      // 5: commit 31->50 in the flush cycle; queue drains during the restore.
      run_restore("t5", 1'b1, 31, 50, 31);
      check("t5 beat0", 32'(beats[0]), 32'(pack_beat(6'd0, 6'd32, 6'd33, 6'd34)));
      check("t5 beat2", 32'(beats[2]), 32'(pack_beat(6'd39, 6'd40, 6'd10, 6'd11)));
      check("t5 beat7_slot3", 32'(beats[7][23:18]), 32'd50);
      check("t5 beat7", 32'(beats[7]), 32'(pack_beat(6'd28, 6'd29, 6'd30, 6'd50)));
      bus.free_ready = 1'b0;

      // 6: re-flush at beat 3 restarts; a mid-restore commit is dropped.
      do_reset();
      check("t6 overflow_clear", 32'(bus.overflow_err), 32'd0);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      #1;
      for (int b = 0; b < 4; b++) begin
         check("t6 first_idx", 32'(bus.restore_idx), 32'(b));
         if (b == 3) bus.flush = 1'b1;
         tick();
      end
      bus.flush = 1'b0;
      #1;
      for (int b = 0; b < NUM_BEATS; b++) begin
         check("t6 restart_valid", 32'(bus.restore_valid), 32'd1);
         check("t6 restart_idx",   32'(bus.restore_idx),   32'(b));
         if (b == 0) begin
            bus.commit_valid = 1'b1;
            bus.commit_areg  = 5'd4;
            bus.commit_preg  = 6'd60;
         end
         if (b == 1) begin
            check("t6 overflow_set", 32'(bus.overflow_err), 32'd1);
            check("t6 dropped_map",  32'(bus.restore_tags[5:0]), 32'd4);
            check("t6 dropped_free", 32'(bus.free_valid), 32'd0);
         end
         tick();
         bus.commit_valid = 1'b0;
      end
      #1;
      check("t6 done", 32'(bus.restore_done), 32'd1);
      tick();

      // 6 (cont.): reset mid-restore aborts and restores the identity map.
      bus.free_ready = 1'b1;
      commit(28, 44);
      tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.free_ready = 1'b0;
      #1;
      check("t6 abort_valid", 32'(bus.restore_valid), 32'd0);
      check("t6 abort_stall", 32'(bus.commit_stall),  32'd0);
      run_restore("t6_post_reset", 1'b0, 0, 0, -1);
      check("t6 identity_beat7", 32'(beats[7]), 32'(pack_beat(6'd28, 6'd29, 6'd30, 6'd31)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rrat_commit.md
Name: rrat_commit

Overview:
- Retirement RAT: the receiving end of the ROB commit interface.
- Holds the committed architectural-to-physical register map (32 arch regs to 6-bit tags).
- On each commit, it updates the map and pushes the displaced physical tag into a freed-tag queue that drains to the free list.
- On flush, it streams the committed map back to the rename-stage RAT over 8 cycles.

Parameters:
- FREE_Q_DEPTH, 8, entries in the freed-tag FIFO (power of two, >=4).
- TAG_W, 6, physical tag width.
- GROUP, 4, arch entries per restore beat (fixed to 4; 32/GROUP beats).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- commit_valid  in  1  commit pulse from ROB (newMap flag).
- commit_areg  in  5  architectural destination.
- commit_preg  in  6  newly committed physical tag.
- commit_stall  out  1  ROB must not commit next cycle.
- flush  in  1  misprediction/syscall flush pulse from ROB.
- free_valid  out  1  freed tag available.
- free_tag  out  6  freed physical tag (FIFO head).
- free_ready  in  1  free list accepts the tag.
- restore_valid  out  1  restore beat valid.
- restore_idx  out  3  beat index g, covering arch 4g..4g+3.
- restore_tags  out  24  [6k+5:6k] = map[4g+k].
- restore_done  out  1  one-cycle pulse after the last beat.
- overflow_err  out  1  sticky: commit was dropped (queue full or during restore).

Behaviour:
- Reset:
  - map[i]=i for all i.
  - FIFO empty; state IDLE.
  - All outputs 0 (commit_stall=0, free_valid=0, restore_*=0, overflow_err=0).
  - Reset mid-restore aborts the restore immediately.
- Commit (state IDLE, commit_valid=1, FIFO not full):
  - areg!=0: old=map[areg]; map[areg]<=preg; push old.
  - areg==0: map unchanged; push commit_preg (the $0 allocation is discarded).
  - New map is visible from the next cycle; the pushed tag appears on free_tag no earlier than the next cycle.
- FIFO:
  - free_valid = (count != 0).
  - Pop when free_valid & free_ready.
  - Push and pop in the same cycle are both honoured, including at full: count unchanged, order preserved.
  - Pointers wrap modulo FREE_Q_DEPTH.
  - count is log2(FREE_Q_DEPTH)+1 bits wide.
- commit_stall = (count >= FREE_Q_DEPTH-1) | (state != IDLE) | flush. Combinational.
- Illegal commits:
  - commit_valid while FIFO full with no simultaneous pop: dropped; map unchanged; overflow_err<=1.
  - commit_valid in RESTORE: dropped; overflow_err<=1.
  - overflow_err is cleared only by reset.
- FSM IDLE -> RESTORE -> DONE -> IDLE:
  - IDLE, flush=1: a commit in the same cycle is applied first. Go to RESTORE with g=0.
  - RESTORE: restore_valid=1, restore_idx=g, restore_tags read from the live map. g increments each cycle. Leave after g=7, so exactly 8 beats.
  - DONE: restore_done=1 for one cycle, then IDLE.
  - flush in RESTORE or DONE restarts at g=0.
  - No backpressure on restore; the rename stage must accept every beat.
- Flush does not clear the FIFO: committed frees are architecturally real.
- The FIFO keeps draining during restore.
- Total flush-to-done latency: flush at cycle t; beats at t+1..t+8; restore_done at t+9; commit_stall drops at t+10.

Decomposition:
- Shared package rrat_pkg:
  - TAG_W, NUM_AREG=32, NUM_PREG=64.
  - State enum {IDLE, RESTORE, DONE}.
  - Function packing 4 tags into a 24-bit beat.
- Sub-module freed_tag_fifo:
  - Parameterized synchronous FIFO, DEPTH and WIDTH.
  - Exposes count, full, empty.
  - Instantiated once here; reusable by LSQ.

Test Plan:
1. Reset, then commit areg=5 preg=40 -> free_tag=5 with free_valid next cycle; a later flush restore beat 1 shows tags[11:6]=40.
2. Commit areg=0 preg=33 -> map unchanged; free_tag=33.
3. free_ready=0, 7 commits (areg 1..7, preg 32..38) -> commit_stall rises when count hits 7. An 8th commit fills the FIFO; a 9th is dropped with overflow_err=1. Drain order is 1..8.
4. FIFO full, commit plus free_ready=1 in the same cycle -> count stays 8; no overflow_err.
5. Commit areg=31 preg=50 in the same cycle as flush -> beats g=0..7 on cycles t+1..t+8; beat 7 tags[23:18]=50; restore_done at t+9; commit_stall high t..t+9.
6. Second flush at beat g=3 -> restart at g=0 and emit 8 full beats. A commit injected mid-restore is dropped and sets overflow_err. Reset mid-restore returns to IDLE with identity map.
